calculate_new_capacity: RTL and testbench

Occupancy-update block of the smart-parking controller. It takes the current parking occupancy bitmap and a one-hot slot selector, then produces the updated bitmap registered on the clock. A car either takes a slot (park) or frees one (leave). Illegal requests (slot selector not one-hot, parking an occupied slot, leaving a free slot) are flagged and leave the map unchanged. It sits between the entry/exit gate logic, which issues requests, and the capacity register/display stage, which consumes `new_capacity` and the free-slot count.

---
 rtl/parking_pkg.sv | 14 +
 rtl/slot_popcount.sv | 19 +
 rtl/calculate_new_capacity.sv | 84 ++++++++
 tb/tb_calculate_new_capacity.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the smart-parking controller: slot count, request
// encodings and the occupancy bitmap type used by gate, update and display blocks.
package parking_pkg;

    localparam int DEFAULT_N_SLOTS = 8;

    typedef enum logic {
        OP_PARK  = 1'b0,
        OP_LEAVE = 1'b1
    } op_e;

    typedef logic [DEFAULT_N_SLOTS-1:0] slot_map_t;

endpackage

// File: rtl/slot_popcount.sv
// Counts the zero (free) bits of an occupancy map.
module slot_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]             map,
    output logic [$clog2(W+1)-1:0]   zeros
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        // NOTE: default assignment first so every path writes zeros and no latch is inferred.
        zeros = '0;
        for (int i = 0; i < W; i++) begin
            zeros = zeros + {{(CW-1){1'b0}}, ~map[i]};
        end
    end

endmodule

// File: rtl/calculate_new_capacity.sv
// Occupancy update: applies one park/leave request per cycle to the caller's
// map, flags illegal requests, and registers the result plus a single flag pulse.
module calculate_new_capacity
    import parking_pkg::*;
#(
    parameter int N_SLOTS = DEFAULT_N_SLOTS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         park_valid,
    input  logic                         op_leave,
    input  logic [N_SLOTS-1:0]           park_location,
    input  logic [N_SLOTS-1:0]           parking_capacity,
    output logic [N_SLOTS-1:0]           new_capacity,
    output logic                         update_ok,
    output logic                         err_not_onehot,
    output logic                         err_conflict,
    output logic [$clog2(N_SLOTS+1)-1:0] free_count,
    output logic                         full
);

    logic [N_SLOTS-1:0] map_d, map_q;
    logic               ok_d, ok_q;
    logic               not_onehot_d, not_onehot_q;
    logic               conflict_d, conflict_q;

    logic is_onehot;
    logic slot_taken;
    logic is_leave;

    assign is_onehot  = (park_location != '0) &&
                        ((park_location & (park_location - 1'b1)) == '0);
    assign slot_taken = |(parking_capacity & park_location);
    assign is_leave   = (op_e'(op_leave) == OP_LEAVE);

    always_comb begin
        map_d        = parking_capacity;
        ok_d         = 1'b0;
        not_onehot_d = 1'b0;
        conflict_d   = 1'b0;
        if (park_valid) begin
            if (!is_onehot) begin
                not_onehot_d = 1'b1;
            end else if (is_leave != slot_taken) begin
                // Leave needs an occupied slot, park needs a free one.
                conflict_d = 1'b1;
            end else begin
                ok_d  = 1'b1;
                map_d = is_leave ? (parking_capacity & ~park_location)
                                 : (parking_capacity | park_location);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            map_q        <= '0;
            ok_q         <= 1'b0;
            not_onehot_q <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            map_q        <= map_d;
            ok_q         <= ok_d;
            not_onehot_q <= not_onehot_d;
            conflict_q   <= conflict_d;
        end
    end

    assign new_capacity   = map_q;
    assign update_ok      = ok_q;
    assign err_not_onehot = not_onehot_q;
    assign err_conflict   = conflict_q;

    slot_popcount #(
        .W (N_SLOTS)
    ) u_slot_popcount (
        .map   (map_q),
        .zeros (free_count)
    );

    assign full = (free_count == '0);

endmodule

// File: tb/tb_calculate_new_capacity.sv
// Directed bench for calculate_new_capacity: a behavioural occupancy model is
// compared every cycle, and hand-computed values pin the model.
module tb_calculate_new_capacity;
    import parking_pkg::*;

    localparam int N   = DEFAULT_N_SLOTS;
    localparam int FCW = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             park_valid = 1'b0;
    logic             op_leave = 1'b0;
    slot_map_t        park_location = '0;
    slot_map_t        parking_capacity = '0;
    slot_map_t        new_capacity;
    logic             update_ok;
    logic             err_not_onehot;
    logic             err_conflict;
    logic [FCW-1:0]   free_count;
    logic             full;

    int tests = 0;
    int fails = 0;
    bit compare_en = 1'b0;

    // Model state: what the registered outputs must be after the last edge.
    slot_map_t exp_map = '0;
    bit        exp_ok = 0, exp_nh = 0, exp_cf = 0;

    calculate_new_capacity #(.N_SLOTS(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .park_valid       (park_valid),
        .op_leave         (op_leave),
        .park_location    (park_location),
        .parking_capacity (parking_capacity),
        .new_capacity     (new_capacity),
        .update_ok        (update_ok),
        .err_not_onehot   (err_not_onehot),
        .err_conflict     (err_conflict),
        .free_count       (free_count),
        .full             (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: slot rules expressed with counts and bit tests.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_map = '0;
            exp_ok = 0; exp_nh = 0; exp_cf = 0;
        end else begin
            exp_map = parking_capacity;
            exp_ok = 0; exp_nh = 0; exp_cf = 0;
            if (park_valid) begin
                if ($countones(park_location) != 1) begin
                    exp_nh = 1;
                end else begin
                    int slot = 0;
                    for (int i = 0; i < N; i++) if (park_location[i]) slot = i;
                    if (op_leave == parking_capacity[slot]) begin
                        exp_ok = 1;
                        exp_map[slot] = ~op_leave;
                    end else begin
                        exp_cf = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (compare_en && rst_n) begin
            check("cyc new_capacity", 32'(new_capacity), 32'(exp_map));
            check("cyc update_ok", 32'(update_ok), 32'(exp_ok));
            check("cyc err_not_onehot", 32'(err_not_onehot), 32'(exp_nh));
            check("cyc err_conflict", 32'(err_conflict), 32'(exp_cf));
            check("cyc free_count", 32'(free_count), 32'(N - $countones(exp_map)));
            check("cyc full", 32'(full), 32'(exp_map == '1));
        end
    end

    task automatic step(input logic v, input logic lv, input slot_map_t loc, input slot_map_t cap);
        @(negedge clk);
        park_valid       = v;
        op_leave         = lv;
        park_location    = loc;
        parking_capacity = cap;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input slot_map_t m, input logic ok,
                              input logic nh, input logic cf, input int fc, input logic fl);
        check({name, " map"}, 32'(new_capacity), 32'(m));
        check({name, " ok"}, 32'(update_ok), 32'(ok));
        check({name, " nh"}, 32'(err_not_onehot), 32'(nh));
        check({name, " cf"}, 32'(err_conflict), 32'(cf));
        check({name, " free"}, 32'(free_count), 32'(fc));
        check({name, " full"}, 32'(full), 32'(fl));
    endtask

    initial begin
        slot_map_t m;
        #2;
        expect_out("reset", 8'h00, 0, 0, 0, N, 0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_en = 1'b1;

        step(1, OP_PARK, 8'b0000_0010, 8'b0101_0101);
        expect_out("park free", 8'b0101_0111, 1, 0, 0, 3, 0);
        step(1, OP_PARK, 8'b0000_0010, 8'b0101_0111);
        expect_out("park occupied", 8'b0101_0111, 0, 0, 1, 3, 0);
        step(1, OP_PARK, 8'b0000_0110, 8'b0101_0111);
        expect_out("two bits", 8'b0101_0111, 0, 1, 0, 3, 0);
        step(1, OP_PARK, 8'b0000_0000, 8'b0101_0111);
        expect_out("zero loc", 8'b0101_0111, 0, 1, 0, 3, 0);
        step(1, OP_LEAVE, 8'b0000_0100, 8'b0101_0111);
        expect_out("leave", 8'b0101_0011, 1, 0, 0, 4, 0);
        step(1, OP_LEAVE, 8'b0000_0100, 8'b0101_0011);
        expect_out("leave free", 8'b0101_0011, 0, 0, 1, 4, 0);
        step(1, OP_PARK, 8'b0000_0001, 8'b1111_1110);
        expect_out("fill", 8'b1111_1111, 1, 0, 0, 0, 1);
        step(1, OP_LEAVE, 8'b1000_0000, 8'b1111_1111);
        expect_out("unfill", 8'b0111_1111, 1, 0, 0, 1, 0);
        step(0, OP_PARK, 8'b0000_0001, 8'b0011_1100);
        expect_out("idle", 8'b0011_1100, 0, 0, 0, 4, 0);
        step(1, OP_LEAVE, 8'b1000_0001, 8'b1000_0001);
        expect_out("leave multi", 8'b1000_0001, 0, 1, 0, 6, 0);

        // Back-to-back fill from empty with feedback, then empty it again.
        m = '0;
        for (int i = 0; i < N; i++) begin
            step(1, OP_PARK, slot_map_t'(1) << i, m);
            m = new_capacity;
        end
        check("b2b full map", 32'(m), 32'hFF);
        for (int i = N - 1; i >= 0; i--) begin
            step(1, OP_LEAVE, slot_map_t'(1) << i, m);
            m = new_capacity;
        end
        check("b2b empty map", 32'(m), 32'h00);

        // Reset asserted between edges while a request is being presented.
        step(1, OP_PARK, 8'b0001_0000, 8'b1110_1111);
        expect_out("pre-reset", 8'hFF, 1, 0, 0, 0, 1);
        @(negedge clk);
        park_valid       = 1'b1;
        op_leave         = OP_PARK;
        park_location    = 8'b0000_0001;
        parking_capacity = 8'b0000_0000;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async reset", 8'h00, 0, 0, 0, N, 0);
        @(negedge clk);
        park_valid       = 1'b0;
        parking_capacity = 8'h00;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        expect_out("post-reset", 8'h00, 0, 0, 0, N, 0);

        step(1, OP_PARK, 8'b0000_0001, 8'h00);
        expect_out("first after reset", 8'h01, 1, 0, 0, N - 1, 0);

        @(negedge clk);
        park_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
